// File: rtl/ps2_mouse_pkg.sv
// Shared constants and types for the PS/2 mouse host controller:
// command/response bytes, controller states and the init step record.
package ps2_mouse_pkg;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_CMD_GET_ID   = 8'hF2;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RATE_200     = 8'hC8;
    localparam logic [7:0] PS2_RATE_100     = 8'h64;
    localparam logic [7:0] PS2_RATE_80      = 8'h50;
    localparam logic [7:0] PS2_ID_STD       = 8'h00;
    localparam logic [7:0] PS2_ID_WHEEL     = 8'h03;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_STEP,
        ST_WAIT_SENT,
        ST_WAIT_ACK,
        ST_WAIT_BYTE,
        ST_WAIT_ID,
        ST_STREAM,
        ST_FAIL
    } state_t;

    // SEND: transmit then expect FA; EXPECT: receive a fixed byte;
    // SEND_ID: transmit, expect FA, then capture the device ID.
    typedef enum logic [1:0] {
        STEP_SEND,
        STEP_EXPECT,
        STEP_SEND_ID
    } step_kind_t;

    typedef struct packed {
        step_kind_t  kind;
        logic [7:0]  data;
        logic        last;
    } step_t;

    function automatic step_t mk_step(input step_kind_t kind, input logic [7:0] data,
                                      input logic last);
        step_t s;
        s.kind = kind;
        s.data = data;
        s.last = last;
        return s;
    endfunction

endpackage

// File: rtl/ps2_init_rom.sv
// Init command ROM: step index (plus wheel-probe enable) to {kind, byte, last}.
module ps2_init_rom
    import ps2_mouse_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic [3:0] idx,
    input  logic       wheel_en,
    output step_t      step
);

    // Base reset/BAT steps, optional IntelliMouse knock, then rate + enable.
    always_comb begin
        step = mk_step(STEP_SEND, PS2_CMD_ENABLE, 1'b1);
        if (wheel_en) begin
            case (idx)
                4'd0:    step = mk_step(STEP_SEND,    PS2_CMD_RESET,    1'b0);
                4'd1:    step = mk_step(STEP_EXPECT,  PS2_RSP_BAT_OK,   1'b0);
                4'd2:    step = mk_step(STEP_EXPECT,  PS2_ID_STD,       1'b0);
                4'd3:    step = mk_step(STEP_SEND,    PS2_CMD_SET_RATE, 1'b0);
                4'd4:    step = mk_step(STEP_SEND,    PS2_RATE_200,     1'b0);
                4'd5:    step = mk_step(STEP_SEND,    PS2_CMD_SET_RATE, 1'b0);
                4'd6:    step = mk_step(STEP_SEND,    PS2_RATE_100,     1'b0);
                4'd7:    step = mk_step(STEP_SEND,    PS2_CMD_SET_RATE, 1'b0);
                4'd8:    step = mk_step(STEP_SEND,    PS2_RATE_80,      1'b0);
                4'd9:    step = mk_step(STEP_SEND_ID, PS2_CMD_GET_ID,   1'b0);
                4'd10:   step = mk_step(STEP_SEND,    PS2_CMD_SET_RATE, 1'b0);
                4'd11:   step = mk_step(STEP_SEND,    SAMPLE_RATE,      1'b0);
                default: step = mk_step(STEP_SEND,    PS2_CMD_ENABLE,   1'b1);
            endcase
        end else begin
            case (idx)
                4'd0:    step = mk_step(STEP_SEND,    PS2_CMD_RESET,    1'b0);
                4'd1:    step = mk_step(STEP_EXPECT,  PS2_RSP_BAT_OK,   1'b0);
                4'd2:    step = mk_step(STEP_EXPECT,  PS2_ID_STD,       1'b0);
                4'd3:    step = mk_step(STEP_SEND,    PS2_CMD_SET_RATE, 1'b0);
                4'd4:    step = mk_step(STEP_SEND,    SAMPLE_RATE,      1'b0);
                default: step = mk_step(STEP_SEND,    PS2_CMD_ENABLE,   1'b1);
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_host_ctrl.sv
// PS/2 mouse host controller: runs the ROM-driven init handshake with
// retries, then streams 3- or 4-byte movement packets to the outputs.
module ps2_mouse_host_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT = 1000000,
    parameter int unsigned BYTE_TIMEOUT = 2000000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned WHEEL_EN     = 1,
    parameter logic [7:0]  SAMPLE_RATE  = 8'd100
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_DZ,
    output logic [7:0] MOUSE_ID,
    output logic       INIT_DONE,
    output logic       INIT_FAIL,
    output logic       SEND_INTERRUPT
);

    localparam int unsigned CNT_MAX = (POWERUP_WAIT > BYTE_TIMEOUT) ? POWERUP_WAIT : BYTE_TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned RW      = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CW-1:0] PU_LAST  = CW'(POWERUP_WAIT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(BYTE_TIMEOUT - 1);
    localparam logic [RW-1:0] TRY_LAST = RW'(MAX_RETRIES - 1);

    state_t        state;
    logic [CW-1:0] tmr;
    logic [RW-1:0] retries;
    logic [3:0]    step_idx;
    step_t         step;
    logic [1:0]    pidx;
    logic [7:0]    sh0, sh1, sh2;
    logic          pkt4;
    logic          irq_pend;
    logic          to_hit;
    logic          rx_good;
    logic          step_pass;
    logic          step_fail;

    ps2_init_rom #(.SAMPLE_RATE(SAMPLE_RATE)) u_rom (
        .idx      (step_idx),
        .wheel_en (WHEEL_EN != 0),
        .step     (step)
    );

    assign to_hit = (tmr == TO_LAST);

    // Judge the current init wait state; a received byte always outranks a timeout.
    always_comb begin
        rx_good   = 1'b0;
        step_pass = 1'b0;
        step_fail = 1'b0;
        case (state)
            ST_WAIT_ACK:  rx_good = (BYTE_ERROR_CODE == 2'b00) && (BYTE_READ == PS2_RSP_ACK);
            ST_WAIT_BYTE: rx_good = (BYTE_ERROR_CODE == 2'b00) && (BYTE_READ == step.data);
            ST_WAIT_ID:   rx_good = (BYTE_ERROR_CODE == 2'b00);
            default:      rx_good = 1'b0;
        endcase
        case (state)
            ST_WAIT_SENT: step_fail = !BYTE_SENT && to_hit;
            ST_WAIT_ACK, ST_WAIT_BYTE, ST_WAIT_ID: begin
                if (BYTE_READY) begin
                    step_pass = rx_good;
                    step_fail = !rx_good;
                end else begin
                    step_fail = to_hit;
                end
            end
            default: ;
        endcase
    end

    // Main controller FSM: init sequencing, retry/fail handling and packet assembly.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_POWERUP;
            tmr            <= '0;
            retries        <= '0;
            step_idx       <= '0;
            pidx           <= '0;
            sh0            <= '0;
            sh1            <= '0;
            sh2            <= '0;
            pkt4           <= 1'b0;
            irq_pend       <= 1'b0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= '0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
            MOUSE_DZ       <= '0;
            MOUSE_ID       <= '0;
            INIT_DONE      <= 1'b0;
            INIT_FAIL      <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
        end else begin
            SEND_BYTE      <= 1'b0;
            irq_pend       <= 1'b0;
            SEND_INTERRUPT <= irq_pend;
            tmr            <= tmr + CW'(1);
            if (step_fail) begin
                tmr         <= '0;
                READ_ENABLE <= 1'b0;
                step_idx    <= '0;
                retries     <= retries + RW'(1);
                if (retries == TRY_LAST) begin
                    state     <= ST_FAIL;
                    INIT_FAIL <= 1'b1;
                end else begin
                    state <= ST_POWERUP;
                end
            end else if (step_pass) begin
                tmr <= '0;
                if (state == ST_WAIT_ACK && step.kind == STEP_SEND_ID) begin
                    state <= ST_WAIT_ID;
                end else begin
                    if (state == ST_WAIT_ID) begin
                        MOUSE_ID <= BYTE_READ;
                        pkt4     <= (BYTE_READ == PS2_ID_WHEEL);
                    end
                    if (step.last) begin
                        state     <= ST_STREAM;
                        INIT_DONE <= 1'b1;
                        pidx      <= '0;
                    end else begin
                        step_idx    <= step_idx + 4'd1;
                        state       <= ST_STEP;
                        READ_ENABLE <= 1'b0;
                    end
                end
            end else begin
                case (state)
                    ST_POWERUP: begin
                        if (tmr == PU_LAST) begin
                            state <= ST_STEP;
                            tmr   <= '0;
                        end
                    end
                    ST_STEP: begin
                        tmr <= '0;
                        if (step.kind == STEP_EXPECT) begin
                            state       <= ST_WAIT_BYTE;
                            READ_ENABLE <= 1'b1;
                        end else begin
                            SEND_BYTE    <= 1'b1;
                            BYTE_TO_SEND <= step.data;
                            state        <= ST_WAIT_SENT;
                        end
                    end
                    ST_WAIT_SENT: begin
                        if (BYTE_SENT) begin
                            state       <= ST_WAIT_ACK;
                            READ_ENABLE <= 1'b1;
                            tmr         <= '0;
                        end
                    end
                    ST_STREAM: begin
                        if (BYTE_READY) begin
                            tmr <= '0;
                            if (BYTE_ERROR_CODE != 2'b00) begin
                                pidx <= '0;
                            end else if (pidx == 2'd0 && !BYTE_READ[3]) begin
                                pidx <= '0;
                            end else if (pidx == (pkt4 ? 2'd3 : 2'd2)) begin
                                MOUSE_STATUS <= sh0;
                                MOUSE_DX     <= sh1;
                                MOUSE_DY     <= pkt4 ? sh2 : BYTE_READ;
                                MOUSE_DZ     <= pkt4 ? BYTE_READ : 8'h00;
                                irq_pend     <= 1'b1;
                                pidx         <= '0;
                            end else begin
                                case (pidx)
                                    2'd0:    sh0 <= BYTE_READ;
                                    2'd1:    sh1 <= BYTE_READ;
                                    default: sh2 <= BYTE_READ;
                                endcase
                                pidx <= pidx + 2'd1;
                            end
                        end else if (pidx == 2'd0) begin
                            tmr <= '0;
                        end else if (to_hit) begin
                            pidx <= '0;
                            tmr  <= '0;
                        end
                    end
                    default: tmr <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_host_ctrl.sv
// Bench for ps2_mouse_host_ctrl: two instances (3-byte mode with 2 tries,
// wheel mode with 3 tries) driven by a behavioural mouse model.
module tb_ps2_mouse_host_ctrl;

    localparam int PU = 20;
    localparam int TO = 60;

    logic       clk;
    logic       rst          [2];
    logic       byte_sent    [2];
    logic [7:0] byte_read    [2];
    logic [1:0] err_code     [2];
    logic       byte_ready   [2];
    logic       send_byte    [2];
    logic [7:0] byte_to_send [2];
    logic       read_enable  [2];
    logic [7:0] status       [2];
    logic [7:0] dx           [2];
    logic [7:0] dy           [2];
    logic [7:0] dz           [2];
    logic [7:0] mid          [2];
    logic       init_done    [2];
    logic       init_fail    [2];
    logic       irq          [2];

    int checks   = 0;
    int failures = 0;
    int send_cnt [2] = '{0, 0};
    int irq_cnt  [2] = '{0, 0};

    // stream model state
    logic [7:0] pq[$];
    int         plen;
    logic [7:0] e_st, e_dx, e_dy, e_dz;
    int         exp_irq;
    int         irq_base;

    ps2_mouse_host_ctrl #(
        .POWERUP_WAIT(PU), .BYTE_TIMEOUT(TO), .MAX_RETRIES(2), .WHEEL_EN(0), .SAMPLE_RATE(8'd100)
    ) u_dut0 (
        .CLK(clk), .RESET(rst[0]), .SEND_BYTE(send_byte[0]), .BYTE_TO_SEND(byte_to_send[0]),
        .BYTE_SENT(byte_sent[0]), .READ_ENABLE(read_enable[0]), .BYTE_READ(byte_read[0]),
        .BYTE_ERROR_CODE(err_code[0]), .BYTE_READY(byte_ready[0]), .MOUSE_STATUS(status[0]),
        .MOUSE_DX(dx[0]), .MOUSE_DY(dy[0]), .MOUSE_DZ(dz[0]), .MOUSE_ID(mid[0]),
        .INIT_DONE(init_done[0]), .INIT_FAIL(init_fail[0]), .SEND_INTERRUPT(irq[0])
    );

    ps2_mouse_host_ctrl #(
        .POWERUP_WAIT(PU), .BYTE_TIMEOUT(TO), .MAX_RETRIES(3), .WHEEL_EN(1), .SAMPLE_RATE(8'd100)
    ) u_dut1 (
        .CLK(clk), .RESET(rst[1]), .SEND_BYTE(send_byte[1]), .BYTE_TO_SEND(byte_to_send[1]),
        .BYTE_SENT(byte_sent[1]), .READ_ENABLE(read_enable[1]), .BYTE_READ(byte_read[1]),
        .BYTE_ERROR_CODE(err_code[1]), .BYTE_READY(byte_ready[1]), .MOUSE_STATUS(status[1]),
        .MOUSE_DX(dx[1]), .MOUSE_DY(dy[1]), .MOUSE_DZ(dz[1]), .MOUSE_ID(mid[1]),
        .INIT_DONE(init_done[1]), .INIT_FAIL(init_fail[1]), .SEND_INTERRUPT(irq[1])
    );

    // 100 MHz-style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // event counters for transmit requests and packet interrupts
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (send_byte[u]) send_cnt[u] <= send_cnt[u] + 1;
            if (irq[u])       irq_cnt[u]  <= irq_cnt[u] + 1;
        end
    end

    // global watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int u);
        return {11'b0, send_byte[u], byte_to_send[u], read_enable[u], status[u], dx[u], dy[u],
                dz[u], mid[u], init_done[u], init_fail[u], irq[u]};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int u);
        rst[u] = 1'b1;
        byte_sent[u] = 1'b0;
        byte_ready[u] = 1'b0;
        err_code[u] = 2'b00;
        idle(3);
        check("reset_outs", outs(u), 64'h0);
        rst[u] = 1'b0;
    endtask

    task automatic wait_send(input int u, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (send_byte[u]) begin
                b = byte_to_send[u];
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_send(input int u);
        check("rd_en_in_send", {63'b0, read_enable[u]}, 64'h0);
        if ($urandom_range(0, 1) == 1) begin
            byte_read[u] = 8'hFA;
            byte_ready[u] = 1'b1;
            @(negedge clk);
            byte_ready[u] = 1'b0;
        end
        idle($urandom_range(0, 2));
        byte_sent[u] = 1'b1;
        @(negedge clk);
        byte_sent[u] = 1'b0;
    endtask

    task automatic rx(input int u, input logic [7:0] b, input logic [1:0] e, input int gap);
        idle(gap);
        byte_read[u] = b;
        err_code[u] = e;
        byte_ready[u] = 1'b1;
        @(negedge clk);
        byte_ready[u] = 1'b0;
        err_code[u] = 2'b00;
    endtask

    // Mouse side of the init handshake; answers FE to the first fe_count resets.
    task automatic run_init(input int u, input int fe_count, input logic [7:0] dev_id);
        logic [7:0] q[$];
        logic [7:0] b;
        bit         ok;
        int         i;
        int         fe;
        int         s0;
        q = {8'hFF};
        if (u == 1) q = {q, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2};
        q = {q, 8'hF3, 8'h64, 8'hF4};
        fe = fe_count;
        i = 0;
        s0 = send_cnt[u];
        while (i < q.size()) begin
            wait_send(u, b, ok);
            if (!ok) begin
                check("send_wait_timeout", 64'h0, 64'h1);
                return;
            end
            check($sformatf("cmd%0d", i), {56'b0, b}, {56'b0, q[i]});
            ack_send(u);
            if (i == 0 && fe > 0) begin
                rx(u, 8'hFE, 2'b00, $urandom_range(2, 5));
                fe--;
                continue;
            end
            rx(u, 8'hFA, 2'b00, $urandom_range(2, 5));
            if (i == 0) begin
                rx(u, 8'hAA, 2'b00, $urandom_range(2, 5));
                rx(u, 8'h00, 2'b00, $urandom_range(2, 5));
            end
            if (q[i] == 8'hF2) rx(u, dev_id, 2'b00, $urandom_range(2, 5));
            i++;
        end
        idle(3);
        check("init_done", {63'b0, init_done[u]}, 64'h1);
        check("init_fail_clear", {63'b0, init_fail[u]}, 64'h0);
        check("stream_rd_en", {63'b0, read_enable[u]}, 64'h1);
        check("mouse_id", {56'b0, mid[u]}, {56'b0, (u == 1) ? dev_id : 8'h00});
        check("send_count", send_cnt[u] - s0, q.size() + fe_count);
    endtask

    task automatic model_clear(input int u);
        pq.delete();
        e_st = 8'h00; e_dx = 8'h00; e_dy = 8'h00; e_dz = 8'h00;
        exp_irq = 0;
        irq_base = irq_cnt[u];
    endtask

    // Feed one stream byte and compare against the queue-based packet model.
    task automatic stream_byte(input int u, input logic [7:0] b, input logic [1:0] e, input int gap);
        bit done;
        done = 1'b0;
        if (gap > TO) pq.delete();
        if (e != 2'b00) begin
            pq.delete();
        end else if (!(pq.size() == 0 && b[3] == 1'b0)) begin
            pq.push_back(b);
            if (pq.size() == plen) begin
                e_st = pq[0];
                e_dx = pq[1];
                e_dy = pq[2];
                e_dz = (plen == 4) ? pq[3] : 8'h00;
                pq.delete();
                exp_irq++;
                done = 1'b1;
            end
        end
        rx(u, b, e, gap);
        check("pkt_outs", {32'b0, status[u], dx[u], dy[u], dz[u]}, {32'b0, e_st, e_dx, e_dy, e_dz});
        check("irq_early", {63'b0, irq[u]}, 64'h0);
        @(negedge clk);
        check("irq_pulse", {63'b0, irq[u]}, {63'b0, done});
        @(negedge clk);
        check("irq_count", irq_cnt[u] - irq_base, exp_irq);
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 9) == 0) ? TO + 20 : $urandom_range(2, 6);
    endfunction

    task automatic rand_stream(input int u, input int npkts);
        logic [7:0] b;
        logic [1:0] e;
        for (int p = 0; p < npkts; p++) begin
            if ($urandom_range(0, 4) == 0) stream_byte(u, 8'($urandom) & 8'hF7, 2'b00, rgap());
            for (int k = 0; k < plen; k++) begin
                b = (k == 0) ? (8'($urandom) | 8'h08) : 8'($urandom);
                e = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                stream_byte(u, b, e, rgap());
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         s0;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            byte_sent[u] = 1'b0;
            byte_read[u] = 8'h00;
            err_code[u] = 2'b00;
            byte_ready[u] = 1'b0;
        end
        idle(2);

        // ---- instance 0: 3-byte mode, two attempts ----
        do_reset(0);
        run_init(0, 0, 8'h00);
        plen = 3;
        model_clear(0);
        stream_byte(0, 8'h08, 2'b00, 3);
        stream_byte(0, 8'h05, 2'b00, 3);
        stream_byte(0, 8'hFB, 2'b00, 3);
        check("req028_pkt", {32'b0, status[0], dx[0], dy[0], dz[0]}, 64'h08_05_FB_00);
        stream_byte(0, 8'h00, 2'b00, 3);
        stream_byte(0, 8'h08, 2'b00, 3);
        stream_byte(0, 8'h01, 2'b00, 3);
        stream_byte(0, 8'h01, 2'b00, 3);
        check("resync_pkt", {32'b0, status[0], dx[0], dy[0], dz[0]}, 64'h08_01_01_00);
        stream_byte(0, 8'h18, 2'b00, 3);
        stream_byte(0, 8'h22, 2'b01, 3);
        stream_byte(0, 8'h28, 2'b00, 3);
        stream_byte(0, 8'h33, 2'b00, 3);
        stream_byte(0, 8'h44, 2'b00, 3);
        check("after_err_pkt", {32'b0, status[0], dx[0], dy[0], dz[0]}, 64'h28_33_44_00);
        stream_byte(0, 8'h38, 2'b00, 3);
        stream_byte(0, 8'h11, 2'b00, TO + 20);
        stream_byte(0, 8'h12, 2'b00, 3);
        rand_stream(0, 10);

        // rejected resets on both attempts -> sticky failure
        do_reset(0);
        s0 = send_cnt[0];
        for (int a = 0; a < 2; a++) begin
            wait_send(0, b, ok);
            check("fail_send_seen", {63'b0, ok}, 64'h1);
            check("fail_cmd", {56'b0, b}, 64'hFF);
            if (ok) begin
                ack_send(0);
                rx(0, 8'hFE, 2'b00, 3);
            end
        end
        idle(5);
        check("init_fail", {63'b0, init_fail[0]}, 64'h1);
        check("fail_rd_en", {63'b0, read_enable[0]}, 64'h0);
        check("fail_done", {63'b0, init_done[0]}, 64'h0);
        idle(300);
        check("fail_no_more_sends", send_cnt[0] - s0, 2);
        check("fail_sticky", {63'b0, init_fail[0]}, 64'h1);

        // transmitter never completes -> both attempts time out
        do_reset(0);
        s0 = send_cnt[0];
        idle(2 * (PU + TO + 10) + 60);
        check("to_init_fail", {63'b0, init_fail[0]}, 64'h1);
        check("to_send_count", send_cnt[0] - s0, 2);
        rst[0] = 1'b1;

        // ---- instance 1: wheel mode, three attempts ----
        do_reset(1);
        run_init(1, 2, 8'h03);
        plen = 4;
        model_clear(1);
        stream_byte(1, 8'h09, 2'b00, 3);
        stream_byte(1, 8'h01, 2'b00, 3);
        stream_byte(1, 8'h02, 2'b00, 3);
        stream_byte(1, 8'hFF, 2'b00, 3);
        check("req029_pkt", {32'b0, status[1], dx[1], dy[1], dz[1]}, 64'h09_01_02_FF);
        rand_stream(1, 10);

        // reset mid-packet clears outputs without a clock edge
        stream_byte(1, 8'h0C, 2'b00, 3);
        stream_byte(1, 8'h07, 2'b00, 3);
        rst[1] = 1'b1;
        #1;
        check("rst_mid_pkt", outs(1), 64'h0);
        idle(2);
        rst[1] = 1'b0;
        run_init(1, 0, 8'h03);
        model_clear(1);

        // reset while a transmit request is on the wire
        rst[1] = 1'b1;
        idle(2);
        rst[1] = 1'b0;
        wait_send(1, b, ok);
        check("send_before_rst", {63'b0, ok}, 64'h1);
        rst[1] = 1'b1;
        #1;
        check("rst_mid_send", outs(1), 64'h0);
        idle(2);
        rst[1] = 1'b0;
        run_init(1, 0, 8'h03);
        model_clear(1);
        rand_stream(1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
